// File: rtl/credit_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : credit_tx_if
//  Purpose  : Bundles the upstream handshake, the send channel toward the
//             receiver and the receiver's credit signals for credit_tx.
//  Ports    : s_valid/s_ready/s_data    upstream word handshake
//             tx_valid/tx_data          registered send strobe and data
//             crd_init_valid/value      initial credit advertisement
//             crd_return                one-credit return pulse
//  Modports : master = environment side, slave = credit_tx side
//  Revision : 1.0  initial release
// ============================================================================
interface credit_tx_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_CREDITS = 8
);
  localparam int CRED_W = $clog2(MAX_CREDITS + 1);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  crd_init_valid;
  logic [CRED_W-1:0]     crd_init_value;
  logic                  crd_return;

  modport master (
    output s_valid, s_data, crd_init_valid, crd_init_value, crd_return,
    input  s_ready, tx_valid, tx_data
  );

  modport slave (
    input  s_valid, s_data, crd_init_valid, crd_init_value, crd_return,
    output s_ready, tx_valid, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/credit_tx.sv
`default_nettype none
// ============================================================================
//  Module   : credit_tx
//  Purpose  : Credit-based sender. Waits for the receiver to advertise a
//             credit pool, then forwards one upstream word per available
//             credit as a registered single-cycle strobe. Returned credits
//             refill the pool; a return beyond the pool saturates and sets a
//             sticky overflow flag.
//  Ports    : clk          clock, rising edge
//             rst_n        synchronous active-low reset
//             bus          credit_tx_if.slave (handshake, send, credit signals)
//             credit_count credits currently available
//             credit_limit pool size latched at init
//             active       high in ACTIVE state
//             err_overflow sticky credit-overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module credit_tx #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  MAX_CREDITS = 8,
  localparam int CRED_W      = $clog2(MAX_CREDITS + 1)
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  credit_tx_if.slave              bus,
  output logic      [CRED_W-1:0]  credit_count,
  output logic      [CRED_W-1:0]  credit_limit,
  output logic                    active,
  output logic                    err_overflow
);

  localparam logic [CRED_W-1:0] c_max_credits = CRED_W'(MAX_CREDITS);
  localparam logic [CRED_W-1:0] c_one         = CRED_W'(1);

  typedef enum logic [0:0] {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CRED_W-1:0]       credit_count_q, credit_count_d;
  logic [CRED_W-1:0]       credit_limit_q, credit_limit_d;
  logic                    err_overflow_q, err_overflow_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;

  logic                    w_active;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_ret;
  logic [CRED_W-1:0]       w_init_clamped;

  assign w_active = (state_q == ST_ACTIVE);
  // Ready looks only at registered credit state, so a return arriving while
  // the pool is empty opens the gate one cycle later, never the same cycle.
  assign w_ready  = w_active && (credit_count_q != '0);
  assign w_accept = bus.s_valid && w_ready;
  assign w_ret    = bus.crd_return && w_active;

  assign w_init_clamped = (bus.crd_init_value > c_max_credits) ? c_max_credits
                                                               : bus.crd_init_value;

  always_comb begin
    state_d        = state_q;
    credit_count_d = credit_count_q;
    credit_limit_d = credit_limit_q;
    err_overflow_d = err_overflow_q;
    tx_valid_d     = w_accept;
    tx_data_d      = w_accept ? bus.s_data : tx_data_q;

    case (state_q)
      ST_INIT: begin
        if (bus.crd_init_valid) begin
          state_d        = ST_ACTIVE;
          credit_count_d = w_init_clamped;
          credit_limit_d = w_init_clamped;
        end
      end
      ST_ACTIVE: begin
        // Simultaneous accept and return cancel out.
        if (w_accept && !w_ret) begin
          credit_count_d = credit_count_q - c_one;
        end else if (w_ret && !w_accept) begin
          if (credit_count_q == credit_limit_q) begin
            err_overflow_d = 1'b1;
          end else begin
            credit_count_d = credit_count_q + c_one;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      credit_count_q <= '0;
      credit_limit_q <= '0;
      err_overflow_q <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      credit_count_q <= credit_count_d;
      credit_limit_q <= credit_limit_d;
      err_overflow_q <= err_overflow_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
    end
  end

  assign bus.s_ready   = w_ready;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign credit_count  = credit_count_q;
  assign credit_limit  = credit_limit_q;
  assign active        = w_active;
  assign err_overflow  = err_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_credit_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_credit_tx
//  Purpose  : Self-checking bench for credit_tx. A reference model tracks
//             credit state; accepted words are queued and compared when the
//             DUT emits its send strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_credit_tx;

  localparam int DW   = 32;
  localparam int MAXC = 8;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] credit_count;
  logic [CW-1:0] credit_limit;
  logic          active;
  logic          err_overflow;

  credit_tx_if #(.DATA_WIDTH(DW), .MAX_CREDITS(MAXC)) bus ();

  credit_tx #(.DATA_WIDTH(DW), .MAX_CREDITS(MAXC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .credit_count (credit_count),
    .credit_limit (credit_limit),
    .active       (active),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobes = 0;
  bit last_acc;

  // reference model
  bit          m_active;
  int          m_cnt;
  int          m_lim;
  bit          m_ovf;
  logic [DW-1:0] m_txd;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs are already applied (driven just after negedge).
  task automatic tick();
    bit rdy, acc, ret, exp_txv;
    int clampv;
    #1;
    rdy = m_active && (m_cnt != 0);
    if (rst_n) check("s_ready", bus.s_ready, rdy);
    acc = rst_n && bus.s_valid && rdy;
    ret = rst_n && bus.crd_return && m_active;
    if (acc) exp_q.push_back(bus.s_data);
    last_acc = acc;
    exp_txv  = acc;
    if (!rst_n) begin
      m_active = 0; m_cnt = 0; m_lim = 0; m_ovf = 0; m_txd = '0;
      exp_q.delete();
    end else if (!m_active) begin
      if (bus.crd_init_valid) begin
        clampv   = (int'(bus.crd_init_value) > MAXC) ? MAXC : int'(bus.crd_init_value);
        m_active = 1;
        m_cnt    = clampv;
        m_lim    = clampv;
      end
    end else if (acc && !ret) begin
      m_cnt--;
    end else if (ret && !acc) begin
      if (m_cnt == m_lim) m_ovf = 1;
      else m_cnt++;
    end
    @(posedge clk);
    #1;
    check("tx_valid", bus.tx_valid, exp_txv);
    if (exp_txv && exp_q.size() > 0) m_txd = exp_q.pop_front();
    check("tx_data", bus.tx_data, m_txd);
    check("credit_count", credit_count, m_cnt);
    check("credit_limit", credit_limit, m_lim);
    check("active", active, m_active);
    check("err_overflow", err_overflow, m_ovf);
    if (bus.tx_valid) n_strobes++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.s_valid        = 1'b0;
    bus.s_data         = '0;
    bus.crd_init_valid = 1'b0;
    bus.crd_init_value = '0;
    bus.crd_return     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic do_init(input int v);
    bus.crd_init_valid = 1'b1;
    bus.crd_init_value = CW'(v);
    tick();
    bus.crd_init_valid = 1'b0;
    bus.crd_init_value = '0;
  endtask

  initial begin
    m_active = 0; m_cnt = 0; m_lim = 0; m_ovf = 0; m_txd = '0;
    idle_inputs();
    rst_n = 1'b0;

    // reset state
    do_reset(2);
    check("rst_active", active, 1'b0);
    check("rst_s_ready", bus.s_ready, 1'b0);
    check("rst_tx_data", bus.tx_data, 32'h0);

    // gating while in INIT
    bus.s_valid = 1'b1; bus.s_data = 32'hDEAD; bus.crd_return = 1'b1;
    repeat (2) tick();
    idle_inputs();
    check("init_gate_count", credit_count, 4'd0);

    // init then burst
    do_init(4);
    n_strobes   = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA0;
    repeat (6) begin
      tick();
      if (last_acc) bus.s_data = bus.s_data + 1;
    end
    check("burst_strobes", n_strobes, 4);
    check("burst_count_end", credit_count, 4'd0);
    check("burst_ready_end", bus.s_ready, 1'b0);
    check("burst_next_data", bus.s_data, 32'hA4);

    // credit return restart
    bus.crd_return = 1'b1;
    tick();
    bus.crd_return = 1'b0;
    check("ret_count", credit_count, 4'd1);
    check("ret_ready", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    check("ret_tx_valid", bus.tx_valid, 1'b1);
    check("ret_tx_data", bus.tx_data, 32'hA4);
    check("ret_count_end", credit_count, 4'd0);

    // second init while active is ignored
    do_init(7);
    check("reinit_limit", credit_limit, 4'd4);
    check("reinit_count", credit_count, 4'd0);

    // simultaneous accept and return
    bus.crd_return = 1'b1;
    repeat (2) tick();
    bus.s_valid = 1'b1; bus.s_data = 32'h55;
    tick();
    idle_inputs();
    check("simul_count", credit_count, 4'd2);
    check("simul_tx_valid", bus.tx_valid, 1'b1);
    tick();

    // overflow
    do_reset(1);
    do_init(3);
    bus.crd_return = 1'b1;
    tick();
    bus.crd_return = 1'b0;
    check("ovf_flag", err_overflow, 1'b1);
    check("ovf_count", credit_count, 4'd3);
    repeat (2) tick();
    check("ovf_sticky", err_overflow, 1'b1);

    // clamp
    do_reset(1);
    do_init(12);
    check("clamp_limit", credit_limit, 4'd8);
    check("clamp_count", credit_count, 4'd8);

    // zero-credit pool
    do_reset(1);
    do_init(0);
    bus.s_valid = 1'b1; bus.s_data = 32'h77; bus.crd_return = 1'b1;
    tick();
    idle_inputs();
    check("zero_active", active, 1'b1);
    check("zero_ready", bus.s_ready, 1'b0);
    check("zero_ovf", err_overflow, 1'b1);

    // reset mid-burst
    do_reset(1);
    do_init(8);
    bus.s_valid = 1'b1; bus.s_data = 32'hB0;
    repeat (3) begin
      tick();
      if (last_acc) bus.s_data = bus.s_data + 1;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_tx_valid", bus.tx_valid, 1'b0);
    check("midrst_count", credit_count, 4'd0);
    check("midrst_limit", credit_limit, 4'd0);
    check("midrst_active", active, 1'b0);
    n_strobes = 0;
    repeat (3) tick();
    check("midrst_no_send", n_strobes, 0);
    do_init(2);
    repeat (3) begin
      tick();
      if (last_acc) bus.s_data = bus.s_data + 1;
    end
    idle_inputs();
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n              = ($urandom_range(0, 59) != 0);
      bus.s_valid        = ($urandom_range(0, 3) != 0);
      bus.s_data         = $urandom;
      bus.crd_return     = ($urandom_range(0, 2) == 0);
      bus.crd_init_valid = ($urandom_range(0, 7) == 0);
      bus.crd_init_value = CW'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
